// File: rtl/alu_dispatch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : alu_dispatch_ctrl
// Purpose  : Single-outstanding ALU dispatcher. Accepts one request in IDLE,
//            enables the selected unit class for one ISSUE cycle, and waits
//            for that unit's done pulse. It then presents a one-cycle
//            completion and returns to IDLE.
//
// Ports    : i_clk        - clock, all state on the rising edge
//            i_rst_n      - synchronous active-low reset (RST)
//            i_in_valid   - request present on i_alu_fun
//            i_alu_fun    - [FUN_W-1 -: SEL_W] unit class, LSBs sub-op
//            o_in_ready   - dispatcher idle, can accept a request
//            o_unit_en    - one-hot unit enable, high only during ISSUE
//            o_op_sel     - sub-op of the last accepted request
//            i_unit_done  - per-unit completion pulse
//            o_out_valid  - one-cycle completion pulse
//            o_out_unit   - class of the last accepted request
//            o_err        - one-cycle watchdog expiry pulse
//
// Config   : define ALU_DISPATCH_TIMEOUT_EN to enable the WAIT watchdog.
//            When it is undefined, WAIT persists until done and o_err is
//            tied low.
//
// Revision : 1.0 - initial release
// ============================================================================
module alu_dispatch_ctrl #(
  parameter int FUN_W       = 4,
  parameter int SEL_W       = 2,
  parameter int TIMEOUT_CYC = 15
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_in_valid,
  input  logic [FUN_W-1:0]          i_alu_fun,
  output logic                      o_in_ready,
  output logic [(2**SEL_W)-1:0]     o_unit_en,
  output logic [FUN_W-SEL_W-1:0]    o_op_sel,
  input  logic [(2**SEL_W)-1:0]     i_unit_done,
  output logic                      o_out_valid,
  output logic [SEL_W-1:0]          o_out_unit,
  output logic                      o_err
);

  localparam int N_UNITS = 2**SEL_W;
  localparam int OP_W    = FUN_W - SEL_W;

  // Elaboration-time sanity checks on the parameter set.
  generate
    if (FUN_W < SEL_W + 1) begin : g_bad_fun_w
      $error("alu_dispatch_ctrl: FUN_W must be at least SEL_W+1");
    end
    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
      $error("alu_dispatch_ctrl: TIMEOUT_CYC must be at least 1");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t               r_state;
  logic [SEL_W-1:0]     r_class;
  logic [OP_W-1:0]      r_op_sel;
  logic [N_UNITS-1:0]   r_unit_en;
  logic                 r_out_valid;

  logic [SEL_W-1:0]     w_req_class;
  logic [OP_W-1:0]      w_req_op;
  logic [N_UNITS-1:0]   w_req_onehot;
  logic                 w_done_hit;

  assign w_req_class  = i_alu_fun[FUN_W-1 -: SEL_W];
  assign w_req_op     = i_alu_fun[OP_W-1:0];
  assign w_req_onehot = {{(N_UNITS-1){1'b0}}, 1'b1} << w_req_class;
  // Only the captured class's done bit matters; other units are ignored.
  assign w_done_hit   = i_unit_done[r_class];

`ifdef ALU_DISPATCH_TIMEOUT_EN
  localparam int                CNT_W      = $clog2(TIMEOUT_CYC + 1);
  // The compare is made against the pre-increment value. The edge that ends
  // the TIMEOUT_CYC-th WAIT cycle is therefore the expiry edge.
  localparam logic [CNT_W-1:0]  c_CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0]     r_cnt;
  logic                 r_err;
`endif

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_class     <= '0;
      r_op_sel    <= '0;
      r_unit_en   <= '0;
      r_out_valid <= 1'b0;
`ifdef ALU_DISPATCH_TIMEOUT_EN
      r_cnt       <= '0;
      r_err       <= 1'b0;
`endif
    end else begin
      // Completion and error are single-cycle pulses by default.
      r_out_valid <= 1'b0;
`ifdef ALU_DISPATCH_TIMEOUT_EN
      r_err       <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (i_in_valid) begin
            r_class   <= w_req_class;
            r_op_sel  <= w_req_op;
            // The enable is registered on the accept edge so it is high
            // for exactly the ISSUE cycle.
            r_unit_en <= w_req_onehot;
            r_state   <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          r_unit_en <= '0;
          r_state   <= S_WAIT;
`ifdef ALU_DISPATCH_TIMEOUT_EN
          r_cnt     <= '0;
`endif
        end

        S_WAIT: begin
`ifdef ALU_DISPATCH_TIMEOUT_EN
          r_cnt <= r_cnt + CNT_W'(1);
`endif
          // Done takes priority over expiry when both fall on the same edge.
          if (w_done_hit) begin
            r_state     <= S_DONE;
            r_out_valid <= 1'b1;
          end
`ifdef ALU_DISPATCH_TIMEOUT_EN
          else if (r_cnt == c_CNT_LAST) begin
            r_state <= S_IDLE;
            r_err   <= 1'b1;
          end
`endif
        end

        S_DONE: begin
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_in_ready  = (r_state == S_IDLE);
  assign o_unit_en   = r_unit_en;
  assign o_op_sel    = r_op_sel;
  assign o_out_valid = r_out_valid;
  assign o_out_unit  = r_class;

`ifdef ALU_DISPATCH_TIMEOUT_EN
  assign o_err = r_err;
`else
  assign o_err = 1'b0;
`endif

endmodule
`default_nettype wire
